// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions used by the MEM stage.
//   RESULT_* : ResultSrc encodings carried through EX/MEM and MEM/WB.
//   mem_state_t : data-bus access state (IDLE, WAIT_RSP).
//   isMemAccess() : true when the EX/MEM instruction touches data memory.
package riscv_pkg;

  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } mem_state_t;

  // A load is marked by ResultSrc selecting memory data; a store by MemWrite.
  function automatic logic isMemAccess(input logic memWrite, input logic [1:0] resultSrc);
    return memWrite | (resultSrc == RESULT_MEM);
  endfunction

endpackage

// File: rtl/mem_access_fsm.sv
// Data-bus access controller for the MEM stage.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   access, isStore     current EX/MEM instruction needs the bus / is a store
//   reqReady, rspValid  bus request accept, load response valid
//   reqValid            bus request valid (forced low while in reset)
//   stall               freeze upstream stages, bubble into MEM/WB
//   rspDone             load response captured this cycle
//   timeoutHit          access force-completed this cycle
//   busTimeout          sticky: some access has timed out since reset
module mem_access_fsm
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic access,
  input  logic isStore,
  input  logic reqReady,
  input  logic rspValid,
  output logic reqValid,
  output logic stall,
  output logic rspDone,
  output logic timeoutHit,
  output logic busTimeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_t       state;
  mem_state_t       stateNext;
  logic [CNT_W-1:0] waitCnt;
  logic             wantStall;

  always_comb begin
    stateNext = state;
    wantStall = 1'b0;
    reqValid  = 1'b0;
    rspDone   = 1'b0;
    case (state)
      IDLE: begin
        // Request stays asserted until accepted; EX/MEM is frozen meanwhile.
        reqValid = access & rst;
        if (access) begin
          if (isStore) begin
            wantStall = ~reqReady;
          end else begin
            wantStall = 1'b1;
            if (reqReady) stateNext = WAIT_RSP;
          end
        end
      end
      WAIT_RSP: begin
        wantStall = ~rspValid;
        rspDone   = rspValid;
        if (rspValid) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    // A cycle that would stall at the limit completes instead; a response
    // arriving in that cycle clears wantStall, so it wins over the timeout.
    timeoutHit = wantStall & (waitCnt == CNT_LIMIT);
    stall      = wantStall & ~timeoutHit;
    if (timeoutHit) stateNext = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      waitCnt    <= '0;
      busTimeout <= 1'b0;
    end else begin
      state <= stateNext;
      if (stall) waitCnt <= waitCnt + 1'b1;
      else       waitCnt <= '0;
      if (timeoutHit) busTimeout <= 1'b1;
    end
  end

endmodule

// File: rtl/memory_cycle.sv
// MEM stage of the 5-stage RISC-V pipeline.
// Consumes the EX/MEM register, issues word loads/stores on a valid/ready
// request + valid-only response bus, stalls upstream while an access is in
// flight, and owns the MEM/WB register.
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   RegWriteM..WriteDataM            EX/MEM register contents
//   mem_req_*                        data-bus request channel
//   mem_rsp_valid, mem_rsp_rdata     data-bus load response
//   StallM                           hold IF/ID/EX and EX/MEM
//   BusTimeoutM                      sticky timeout indicator
//   RegWriteW..ReadDataW             MEM/WB register outputs
module memory_cycle
  import riscv_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] ALU_ResultM,
  input  logic [31:0] WriteDataM,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_we,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata,
  output logic        StallM,
  output logic        BusTimeoutM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW
);

  logic access;
  logic isLoad;
  logic rspDone;
  logic timeoutHit;

  assign access = isMemAccess(MemWriteM, ResultSrcM);
  // An instruction flagged as both store and load is treated as a store.
  assign isLoad = (ResultSrcM == RESULT_MEM) & ~MemWriteM;

  assign mem_req_we    = MemWriteM;
  assign mem_req_addr  = {ALU_ResultM[31:2], 2'b00};
  assign mem_req_wdata = WriteDataM;

  mem_access_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) uFsm (
    .clk        (clk),
    .rst        (rst),
    .access     (access),
    .isStore    (MemWriteM),
    .reqReady   (mem_req_ready),
    .rspValid   (mem_rsp_valid),
    .reqValid   (mem_req_valid),
    .stall      (StallM),
    .rspDone    (rspDone),
    .timeoutHit (timeoutHit),
    .busTimeout (BusTimeoutM)
  );

  // MEM/WB register boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW   <= 1'b0;
      ResultSrcW  <= RESULT_ALU;
      RD_W        <= 5'd0;
      PCPlus4W    <= 32'd0;
      ALU_ResultW <= 32'd0;
      ReadDataW   <= 32'd0;
    end else if (StallM) begin
      // Bubble: the held instruction must not be written back more than once.
      RegWriteW  <= 1'b0;
      ResultSrcW <= RESULT_ALU;
      RD_W       <= 5'd0;
    end else begin
      RegWriteW   <= RegWriteM;
      ResultSrcW  <= ResultSrcM;
      RD_W        <= RD_M;
      PCPlus4W    <= PCPlus4M;
      ALU_ResultW <= ALU_ResultM;
      if (rspDone)                  ReadDataW <= mem_rsp_rdata;
      else if (timeoutHit && isLoad) ReadDataW <= TIMEOUT_RDATA;
    end
  end

endmodule

// File: tb/tb_memory_cycle.sv
// Randomized self-checking bench for memory_cycle.
// Each instruction is described by its kind, its fields, the number of
// cycles the bus keeps ready low (r) and the response delay after accept (d).
// Expected stall count, timeout and MEM/WB contents follow directly from
// those numbers and the timeout limit.
module tb_memory_cycle;

  localparam int          TO       = 4;
  localparam logic [31:0] TO_RDATA = 32'hBADC0DE5;
  localparam int          NEVER    = 1000;
  localparam int          K_ALU    = 0;
  localparam int          K_PC4    = 1;
  localparam int          K_LOAD   = 2;
  localparam int          K_STORE  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM;
  logic        MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M;
  logic [31:0] ALU_ResultM;
  logic [31:0] WriteDataM;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        StallM;
  logic        BusTimeoutM;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W;
  logic [31:0] ALU_ResultW;
  logic [31:0] ReadDataW;

  always #5 clk = ~clk;

  memory_cycle #(
    .TIMEOUT_CYCLES(TO),
    .TIMEOUT_RDATA (TO_RDATA)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .RegWriteM    (RegWriteM),
    .MemWriteM    (MemWriteM),
    .ResultSrcM   (ResultSrcM),
    .RD_M         (RD_M),
    .PCPlus4M     (PCPlus4M),
    .ALU_ResultM  (ALU_ResultM),
    .WriteDataM   (WriteDataM),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_we   (mem_req_we),
    .mem_req_addr (mem_req_addr),
    .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_rdata(mem_rsp_rdata),
    .StallM       (StallM),
    .BusTimeoutM  (BusTimeoutM),
    .RegWriteW    (RegWriteW),
    .ResultSrcW   (ResultSrcW),
    .RD_W         (RD_W),
    .PCPlus4W     (PCPlus4W),
    .ALU_ResultW  (ALU_ResultW),
    .ReadDataW    (ReadDataW)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] readDataMdl;
  logic        timeoutMdl;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic checkWZero(input string tag);
    chk({tag, ".RegWriteW"},   32'(RegWriteW),  32'd0);
    chk({tag, ".ResultSrcW"},  32'(ResultSrcW), 32'd0);
    chk({tag, ".RD_W"},        32'(RD_W),       32'd0);
    chk({tag, ".PCPlus4W"},    PCPlus4W,        32'd0);
    chk({tag, ".ALU_ResultW"}, ALU_ResultW,     32'd0);
    chk({tag, ".ReadDataW"},   ReadDataW,       32'd0);
  endtask

  // Called at a negedge; returns at the negedge after the instruction leaves MEM.
  task automatic runInstr(input int kind, input logic regWrite, input logic [4:0] rd,
                          input logic [31:0] alu, input logic [31:0] wdata,
                          input logic [31:0] pc4, input int r, input int d,
                          input logic [31:0] rspData);
    logic [1:0] rsrc;
    bit         access;
    bit         isStore;
    bit         accepted;
    bit         done;
    bit         wasStall;
    bit         expTimeout;
    int         acceptCyc;
    int         cyc;
    int         stallCnt;
    int         target;
    int         expStalls;

    case (kind)
      K_LOAD:  rsrc = 2'b01;
      K_PC4:   rsrc = 2'b10;
      K_STORE: rsrc = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
      default: rsrc = 2'b00;
    endcase
    isStore    = (kind == K_STORE);
    access     = (kind == K_LOAD) || isStore;
    target     = isStore ? r : r + d;
    expStalls  = !access ? 0 : ((target > TO - 1) ? TO - 1 : target);
    expTimeout = access && (target > TO - 1);

    RegWriteM   = regWrite;
    MemWriteM   = isStore;
    ResultSrcM  = rsrc;
    RD_M        = rd;
    PCPlus4M    = pc4;
    ALU_ResultM = alu;
    WriteDataM  = wdata;

    accepted  = 0;
    acceptCyc = 0;
    stallCnt  = 0;
    done      = 0;
    cyc       = 0;
    while (!done && cyc < 64) begin
      if (access) mem_req_ready = (cyc >= r);
      else        mem_req_ready = 1'($urandom_range(0, 1));
      // Before a load is accepted the response line is noise that must be ignored.
      if (accepted) mem_rsp_valid = (d != NEVER) && (cyc == acceptCyc + d);
      else          mem_rsp_valid = 1'($urandom_range(0, 1));
      mem_rsp_rdata = (accepted && mem_rsp_valid) ? rspData : $urandom;
      #1;
      if (access && !accepted) begin
        chk("reqValid", 32'(mem_req_valid), 32'd1);
        chk("reqAddr",  mem_req_addr, {alu[31:2], 2'b00});
        chk("reqWe",    32'(mem_req_we), 32'(isStore));
        if (isStore) chk("reqWdata", mem_req_wdata, wdata);
      end else begin
        chk("reqValidOff", 32'(mem_req_valid), 32'd0);
      end
      if (access && !isStore && !accepted && mem_req_ready) begin
        accepted  = 1;
        acceptCyc = cyc;
      end
      wasStall = StallM;
      @(negedge clk);
      if (wasStall) begin
        stallCnt++;
        chk("bubbleRegWrite", 32'(RegWriteW),  32'd0);
        chk("bubbleRd",       32'(RD_W),       32'd0);
        chk("bubbleSrc",      32'(ResultSrcW), 32'd0);
      end else begin
        done = 1;
      end
      cyc++;
    end
    chk("completed", 32'(done), 32'd1);
    chk("stallCycles", 32'(stallCnt), 32'(expStalls));

    if (kind == K_LOAD) readDataMdl = expTimeout ? TO_RDATA : rspData;
    if (expTimeout) timeoutMdl = 1'b1;
    chk("RegWriteW",   32'(RegWriteW),   32'(regWrite));
    chk("RD_W",        32'(RD_W),        32'(rd));
    chk("ResultSrcW",  32'(ResultSrcW),  32'(rsrc));
    chk("PCPlus4W",    PCPlus4W,         pc4);
    chk("ALU_ResultW", ALU_ResultW,      alu);
    chk("ReadDataW",   ReadDataW,        readDataMdl);
    chk("BusTimeoutM", 32'(BusTimeoutM), 32'(timeoutMdl));
  endtask

  initial begin
    int kind;
    int r;
    int d;

    readDataMdl   = 32'd0;
    timeoutMdl    = 1'b0;
    rst           = 1'b0;
    RegWriteM     = 1'b1;
    MemWriteM     = 1'b0;
    ResultSrcM    = 2'b01;
    RD_M          = 5'd7;
    PCPlus4M      = 32'h44;
    ALU_ResultM   = 32'h80;
    WriteDataM    = 32'h0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h55AA55AA;

    // Reset with a load pending on the inputs: no request may escape.
    #1;
    chk("rstReqValid", 32'(mem_req_valid), 32'd0);
    repeat (3) @(negedge clk);
    chk("rstReqValidHeld", 32'(mem_req_valid), 32'd0);
    chk("rstBusTimeout", 32'(BusTimeoutM), 32'd0);
    checkWZero("rst");
    rst = 1'b1;

    // Directed cases.
    runInstr(K_ALU,   1'b1, 5'd5, 32'h10,  32'h0,        32'h1004, 0, 0, 32'h0);
    runInstr(K_STORE, 1'b0, 5'd0, 32'h103, 32'hCAFEF00D, 32'h1008, 0, 0, 32'h0);
    runInstr(K_LOAD,  1'b1, 5'd9, 32'h20,  32'h0,        32'h100C, 0, 1, 32'h12345678);
    runInstr(K_LOAD,  1'b1, 5'd3, 32'h24,  32'h0,        32'h1010, 3, 2, 32'h0BADF00D);
    runInstr(K_ALU,   1'b1, 5'd4, 32'h99,  32'h0,        32'h1014, 0, 0, 32'h0);
    runInstr(K_LOAD,  1'b1, 5'd6, 32'h28,  32'h0,        32'h1018, 0, NEVER, 32'h0);
    runInstr(K_STORE, 1'b0, 5'd0, 32'h2C,  32'h13572468, 32'h101C, 7, 0, 32'h0);
    runInstr(K_LOAD,  1'b1, 5'd8, 32'h30,  32'h0,        32'h1020, 1, 2, 32'hFEEDBEEF);
    runInstr(K_STORE, 1'b0, 5'd0, 32'h34,  32'h11112222, 32'h1024, 3, 0, 32'h0);

    // Reset while a load waits for its response.
    RegWriteM     = 1'b1;
    MemWriteM     = 1'b0;
    ResultSrcM    = 2'b01;
    RD_M          = 5'd12;
    PCPlus4M      = 32'h2000;
    ALU_ResultM   = 32'h40;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("midRstReqValid", 32'(mem_req_valid), 32'd0);
    chk("midRstBusTimeout", 32'(BusTimeoutM), 32'd0);
    checkWZero("midRst");
    @(negedge clk);
    chk("midRstReqValidHeld", 32'(mem_req_valid), 32'd0);
    rst         = 1'b1;
    readDataMdl = 32'd0;
    timeoutMdl  = 1'b0;
    runInstr(K_LOAD, 1'b1, 5'd13, 32'h48, 32'h0, 32'h2004, 0, 1, 32'hA5A5C3C3);

    // Randomized instruction stream.
    for (int i = 0; i < 250; i++) begin
      kind = int'($urandom_range(0, 3));
      r    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(3, 6)) : int'($urandom_range(0, 2));
      d    = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(1, 3));
      runInstr(kind, (kind == K_STORE) ? 1'b0 : 1'($urandom_range(0, 1)),
               5'($urandom), $urandom, $urandom, $urandom, r, d, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
